pc_update_ctrl: RTL and testbench
=================================

Name: pc_update_ctrl

Overview:
- Parametrised successor to the SEQ PC-update logic for the Y86-64 processor.
- Holds the architectural PC in a true clocked register with synchronous reset and stall.
- Selects the next PC from valP, valC or valM per icode/Cnd.
- Tracks processor status (AOK/HLT/ADR/INS) with a run/halt/error state machine and freezes the PC once execution stops.
- Sits after the write-back stage; drives the fetch address.

Parameters:
- ADDR_W, 64, width of PC, valC, valP, valM.
- RESET_PC, 0, PC value loaded on reset (ADDR_W bits).
- CNT_W, 32, width of statistics counters (used only with the optional feature).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr_valid  input  1  current instruction's stage values are valid and may commit.
- stall  input  1  hold PC and state this cycle; overrides instr_valid.
- icode  input  4  Y86 instruction code of the committing instruction.
- Cnd  input  1  branch condition from execute.
- valC  input  ADDR_W  constant/target from fetch.
- valP  input  ADDR_W  fall-through address.
- valM  input  ADDR_W  value read from memory (return address).
- imem_error  input  1  fetch address error for this instruction.
- dmem_error  input  1  data memory address error for this instruction.
- PC  output  ADDR_W  registered program counter.
- stat  output  3  registered status: 1=AOK, 2=HLT, 3=ADR, 4=INS.
- running  output  1  registered; high only in RUN state.
- redirect  output  1  registered one-cycle pulse: last commit took a non-sequential PC (taken jXX, call, ret).
- retire  output  1  registered one-cycle pulse: an instruction committed last cycle.

Behaviour:
- Reset: PC=RESET_PC, stat=1, running=1, redirect=0, retire=0, state=RUN. Reset wins over every other input, in any state, including mid-stall.
- commit = running & instr_valid & ~stall. When commit=0: PC, stat and state hold; redirect=0 and retire=0 next cycle.
- States: RUN, HALT, ERR. HALT and ERR are sticky until rst; running=0 in both.
- On commit, evaluate in strict priority order:
  - imem_error|dmem_error -> state ERR, stat=3, PC holds.
  - else icode>11 -> state ERR, stat=4, PC holds.
  - else icode==0 (halt) -> state HALT, stat=2, PC holds.
  - else PC <= next_pc, stat stays 1, retire=1 next cycle.
- next_pc selection:
  - icode 7 (jXX): Cnd ? valC : valP.
  - icode 8 (call): valC.
  - icode 9 (ret): valM.
  - all other valid icodes (1-6, A, B): valP.
- redirect=1 next cycle iff commit with icode 8, icode 9, or icode 7 with Cnd=1. A taken jump is flagged even when valC==valP.
- retire is 0 for halting/faulting commits; those commits are not counted as retired.
- Arithmetic: no address computation; values pass through at ADDR_W bits. No alignment check. Wrap-around is the producer's responsibility.
- Latency: one clock from commit to updated PC/stat/pulses.
- Simultaneous events:
  - stall=1 with instr_valid=1 -> no commit.
  - Error plus halt icode -> ERR/ADR.
  - Error plus invalid icode -> ADR.
- Only signals are registered; no combinational path from inputs to outputs.

Optional Feature:
- Macro: PC_STATS_EN.
- When defined, adds outputs:
  - n_retired  output  CNT_W  count of retire pulses.
  - n_taken  output  CNT_W  count of redirect pulses.
- Both counters clear on rst and saturate at all-ones (no wrap).
- Each counter increments in the same edge that raises its pulse.
- When undefined, the ports and counters are absent. Core behaviour is identical in both builds.

Test Plan:
- Reset with RESET_PC=0x100 -> PC=0x100, stat=1, running=1. Then commit icode=1, valP=0x101 -> PC=0x101, retire pulse, redirect=0.
- Commit icode=7, valC=0x200, valP=0x109: Cnd=1 -> PC=0x200 with redirect; Cnd=0 -> PC=0x109 with no redirect.
- Commit icode=8, valC=0x300 -> PC=0x300. Then icode=9, valM=0x115 -> PC=0x115. redirect pulses on both.
- stall=1 with instr_valid=1 for 3 cycles -> PC unchanged, no pulses. Release -> commit proceeds normally.
- Commit icode=0 at PC=0x40 -> stat=2, running=0, PC stays 0x40. Later commits are ignored. Assert rst -> PC=RESET_PC, stat=1.
- Commit icode=0xC -> stat=4. Separately, dmem_error=1 with icode=0xC -> stat=3. PC frozen in both. With PC_STATS_EN: after 5 retires and 2 redirects, n_retired=5 and n_taken=2; counters clear on rst.

Source files
------------

// File: rtl/pc_update_ctrl.sv
// rtl/pc_update_ctrl.sv - Y86-64 PC register, next-PC select and run/halt/error status tracking
// Define PC_STATS_EN to add saturating retire/redirect counters (n_retired, n_taken).
module pc_update_ctrl #(
  parameter int                ADDR_W   = 64,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                CNT_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  input  logic              stall,
  input  logic [3:0]        icode,
  input  logic              Cnd,
  input  logic [ADDR_W-1:0] valC,
  input  logic [ADDR_W-1:0] valP,
  input  logic [ADDR_W-1:0] valM,
  input  logic              imem_error,
  input  logic              dmem_error,
  output logic [ADDR_W-1:0] PC,
  output logic [2:0]        stat,
  output logic              running,
  output logic              redirect,
  output logic              retire
`ifdef PC_STATS_EN
  ,
  output logic [CNT_W-1:0]  n_retired,
  output logic [CNT_W-1:0]  n_taken
`endif
);

  localparam logic [2:0] STAT_AOK = 3'd1;
  localparam logic [2:0] STAT_HLT = 3'd2;
  localparam logic [2:0] STAT_ADR = 3'd3;
  localparam logic [2:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {S_RUN, S_HALT, S_ERR} state_t;
  state_t state;

  logic              commit;
  logic              fault;
  logic              bad_icode;
  logic              is_halt;
  logic              do_retire;
  logic              taken;
  logic [ADDR_W-1:0] next_pc;

  always_comb begin
    commit    = (state == S_RUN) & instr_valid & ~stall;
    fault     = imem_error | dmem_error;
    bad_icode = icode > 4'd11;
    is_halt   = icode == 4'd0;
    do_retire = commit & ~fault & ~bad_icode & ~is_halt;
    next_pc   = valP;
    taken     = 1'b0;
    case (icode)
      4'd7: begin
        // A taken jump redirects even when valC happens to equal valP.
        if (Cnd) begin
          next_pc = valC;
          taken   = 1'b1;
        end
      end
      4'd8: begin
        next_pc = valC;
        taken   = 1'b1;
      end
      4'd9: begin
        next_pc = valM;
        taken   = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_RUN;
      PC       <= RESET_PC;
      stat     <= STAT_AOK;
      running  <= 1'b1;
      redirect <= 1'b0;
      retire   <= 1'b0;
    end else begin
      redirect <= 1'b0;
      retire   <= 1'b0;
      case (state)
        S_RUN: begin
          if (commit) begin
            // Address faults outrank both invalid and halt icodes.
            if (fault) begin
              state   <= S_ERR;
              stat    <= STAT_ADR;
              running <= 1'b0;
            end else if (bad_icode) begin
              state   <= S_ERR;
              stat    <= STAT_INS;
              running <= 1'b0;
            end else if (is_halt) begin
              state   <= S_HALT;
              stat    <= STAT_HLT;
              running <= 1'b0;
            end else begin
              PC       <= next_pc;
              retire   <= 1'b1;
              redirect <= taken;
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef PC_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      n_retired <= '0;
      n_taken   <= '0;
    end else begin
      if (do_retire && (n_retired != '1))
        n_retired <= n_retired + 1'b1;
      if (do_retire && taken && (n_taken != '1))
        n_taken <= n_taken + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_pc_update_ctrl.sv
// tb/tb_pc_update_ctrl.sv - self-checking bench for pc_update_ctrl (vector table, corner sequences, random vs model)
module tb_pc_update_ctrl;

  localparam logic [63:0] RPC = 64'h100;

  logic        clk = 1'b0;
  logic        rst, instr_valid, stall, Cnd, imem_error, dmem_error;
  logic [3:0]  icode;
  logic [63:0] valC, valP, valM, PC;
  logic [2:0]  stat;
  logic        running, redirect, retire;
`ifdef PC_STATS_EN
  logic [31:0] n_retired, n_taken;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pc_update_ctrl #(.ADDR_W(64), .RESET_PC(RPC), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .instr_valid(instr_valid), .stall(stall),
    .icode(icode), .Cnd(Cnd), .valC(valC), .valP(valP), .valM(valM),
    .imem_error(imem_error), .dmem_error(dmem_error),
    .PC(PC), .stat(stat), .running(running), .redirect(redirect), .retire(retire)
`ifdef PC_STATS_EN
    , .n_retired(n_retired), .n_taken(n_taken)
`endif
  );

  typedef struct {
    logic        r, v, s;
    logic [3:0]  ic;
    logic        c;
    logic [63:0] vc, vp, vm;
    logic        ie, de;
    logic [63:0] epc;
    logic [2:0]  est;
    logic        erun, ered, eret;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic v, logic s, logic [3:0] ic, logic c,
                              logic [63:0] vc, logic [63:0] vp, logic [63:0] vm,
                              logic ie, logic de, logic [63:0] epc, logic [2:0] est,
                              logic erun, logic ered, logic eret);
    vec_t t;
    t.r = r; t.v = v; t.s = s; t.ic = ic; t.c = c; t.vc = vc; t.vp = vp; t.vm = vm;
    t.ie = ie; t.de = de; t.epc = epc; t.est = est; t.erun = erun; t.ered = ered; t.eret = eret;
    return t;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic r, input logic v, input logic s, input logic [3:0] ic,
                       input logic c, input logic [63:0] vc, input logic [63:0] vp,
                       input logic [63:0] vm, input logic ie, input logic de);
    rst = r; instr_valid = v; stall = s; icode = ic; Cnd = c;
    valC = vc; valP = vp; valM = vm; imem_error = ie; dmem_error = de;
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [63:0] epc, input logic [2:0] est,
                            input logic erun, input logic ered, input logic eret);
    chk({tag, ".PC"}, PC, epc);
    chk({tag, ".stat"}, {61'd0, stat}, {61'd0, est});
    chk({tag, ".running"}, {63'd0, running}, {63'd0, erun});
    chk({tag, ".redirect"}, {63'd0, redirect}, {63'd0, ered});
    chk({tag, ".retire"}, {63'd0, retire}, {63'd0, eret});
  endtask

  // Reference model state: architectural PC, status code and stats.
  logic [63:0] m_pc;
  logic [2:0]  m_stat;
  logic        m_red, m_ret;
  longint      m_nret, m_ntak;

  task automatic model_step(input logic r, input logic v, input logic s, input logic [3:0] ic,
                            input logic c, input logic [63:0] vc, input logic [63:0] vp,
                            input logic [63:0] vm, input logic ie, input logic de);
    m_red = 1'b0;
    m_ret = 1'b0;
    if (r) begin
      m_pc = RPC; m_stat = 3'd1; m_nret = 0; m_ntak = 0;
    end else if (m_stat == 3'd1 && v && !s) begin
      if (ie || de)          m_stat = 3'd3;
      else if (ic > 4'd11)   m_stat = 3'd4;
      else if (ic == 4'd0)   m_stat = 3'd2;
      else begin
        m_ret = 1'b1;
        if (ic == 4'd7)      begin m_pc = c ? vc : vp; m_red = c; end
        else if (ic == 4'd8) begin m_pc = vc; m_red = 1'b1; end
        else if (ic == 4'd9) begin m_pc = vm; m_red = 1'b1; end
        else                 m_pc = vp;
        m_nret++;
        if (m_red) m_ntak++;
      end
    end
  endtask

  initial begin
    // rst v s ic c valC valP valM ie de | PC stat run red ret
    vq.push_back(mk(1,0,0,4'h0,0,0,0,0,0,0,         RPC,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'h1,0,0,64'h101,0,0,0,   64'h101,3'd1,1,0,1));
    vq.push_back(mk(0,1,0,4'h7,1,64'h200,64'h109,0,0,0, 64'h200,3'd1,1,1,1));
    vq.push_back(mk(0,1,0,4'h7,0,64'h200,64'h109,0,0,0, 64'h109,3'd1,1,0,1));
    vq.push_back(mk(0,1,0,4'h8,0,64'h300,64'h10a,0,0,0, 64'h300,3'd1,1,1,1));
    vq.push_back(mk(0,1,0,4'h9,0,0,64'h302,64'h115,0,0, 64'h115,3'd1,1,1,1));
    vq.push_back(mk(0,1,1,4'h8,0,64'h999,64'h1,0,0,0, 64'h115,3'd1,1,0,0));
    vq.push_back(mk(0,1,1,4'h8,0,64'h999,64'h1,0,0,0, 64'h115,3'd1,1,0,0));
    vq.push_back(mk(0,1,1,4'h8,0,64'h999,64'h1,0,0,0, 64'h115,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'h2,0,0,64'h117,0,0,0,   64'h117,3'd1,1,0,1));
    vq.push_back(mk(0,0,0,4'h8,0,64'h555,0,0,0,0,   64'h117,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'h7,1,64'h40,64'h40,0,0,0, 64'h40,3'd1,1,1,1));
    vq.push_back(mk(0,1,0,4'h0,0,0,64'h41,0,0,0,    64'h40,3'd2,0,0,0));
    vq.push_back(mk(0,1,0,4'h1,0,0,64'h50,0,0,0,    64'h40,3'd2,0,0,0));
    vq.push_back(mk(1,1,0,4'h1,0,0,64'h50,0,0,0,    RPC,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'hC,0,0,64'h777,0,0,0,   RPC,3'd4,0,0,0));
    vq.push_back(mk(0,1,0,4'h1,0,0,64'h777,0,0,0,   RPC,3'd4,0,0,0));
    vq.push_back(mk(1,1,1,4'h1,0,0,64'h777,0,0,0,   RPC,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'hC,0,0,64'h777,0,0,1,   RPC,3'd3,0,0,0));
    vq.push_back(mk(1,0,0,4'h0,0,0,0,0,0,0,         RPC,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'h0,0,0,64'h777,0,1,0,   RPC,3'd3,0,0,0));
    vq.push_back(mk(1,0,0,4'h0,0,0,0,0,0,0,         RPC,3'd1,1,0,0));
    vq.push_back(mk(0,1,0,4'hB,0,0,64'h123,0,0,0,   64'h123,3'd1,1,0,1));

    foreach (vq[i]) begin
      drive(vq[i].r, vq[i].v, vq[i].s, vq[i].ic, vq[i].c, vq[i].vc, vq[i].vp, vq[i].vm,
            vq[i].ie, vq[i].de);
      check_outs($sformatf("vec%0d", i), vq[i].epc, vq[i].est, vq[i].erun, vq[i].ered, vq[i].eret);
    end

`ifdef PC_STATS_EN
    // 5 retires, 2 of them redirecting, then clear on reset.
    drive(1,0,0,4'h0,0,0,0,0,0,0);
    drive(0,1,0,4'h1,0,0,64'h110,0,0,0);
    drive(0,1,0,4'h7,1,64'h200,64'h120,0,0,0);
    drive(0,1,1,4'h8,0,64'h300,0,0,0,0);
    drive(0,1,0,4'h8,0,64'h300,64'h210,0,0,0);
    drive(0,1,0,4'h2,0,0,64'h310,0,0,0);
    drive(0,1,0,4'h7,0,64'h400,64'h320,0,0,0);
    chk("stats.n_retired", {32'd0, n_retired}, 64'd5);
    chk("stats.n_taken", {32'd0, n_taken}, 64'd2);
    drive(1,0,0,4'h0,0,0,0,0,0,0);
    chk("stats.n_retired_rst", {32'd0, n_retired}, 64'd0);
    chk("stats.n_taken_rst", {32'd0, n_taken}, 64'd0);
`endif

    model_step(1,0,0,4'h0,0,0,0,0,0,0);
    drive(1,0,0,4'h0,0,0,0,0,0,0);
    for (int n = 0; n < 600; n++) begin
      logic r, v, s, c, ie, de;
      logic [3:0] ic;
      logic [63:0] vc, vp, vm;
      r  = ($urandom_range(0, 39) == 0);
      v  = ($urandom_range(0, 3) != 0);
      s  = ($urandom_range(0, 4) == 0);
      c  = $urandom_range(0, 1);
      ie = ($urandom_range(0, 59) == 0);
      de = ($urandom_range(0, 59) == 0);
      ic = ($urandom_range(0, 11) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(1, 11));
      vc = {$urandom, $urandom};
      vp = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      model_step(r, v, s, ic, c, vc, vp, vm, ie, de);
      drive(r, v, s, ic, c, vc, vp, vm, ie, de);
      check_outs($sformatf("rnd%0d", n), m_pc, m_stat, m_stat == 3'd1, m_red, m_ret);
`ifdef PC_STATS_EN
      chk($sformatf("rnd%0d.n_retired", n), {32'd0, n_retired}, 64'(m_nret));
      chk($sformatf("rnd%0d.n_taken", n), {32'd0, n_taken}, 64'(m_ntak));
`endif
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
